// File: rtl/data_ram.sv
// data_ram: load/store responder RAM for the execute stage.
// Byte/half/word stores are placed into their lanes inside the RAM. Reads
// return the full aligned word one cycle later, along with the byte
// address it belongs to. Misaligned stores are dropped and counted.
// Optional build macro DRAM_CLEAR_EN: zero-scrubs the whole array after
// reset release. o_busy is high while the scrub runs.
module data_ram #(
  parameter int    DEPTH_LOG2 = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic        i_Clk,
  input  logic        i_reset_n,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_r_addr,
  input  logic [31:0] i_mem_w_addr,
  input  logic [31:0] i_mem_w_data,
  input  logic [1:0]  i_mem_len,
  output logic [31:0] o_mem_r_data,
  output logic [31:0] o_mem_r_addr,
  output logic        o_misalign,
  output logic [7:0]  o_misalign_cnt,
  output logic        o_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] scrub_idx;
  logic [3:0]            lane_en;
  logic [3:0]            wr_be;
  logic [31:0]           lane_data;
  logic [31:0]           wr_word;
  logic [31:0]           mem_word;
  logic [31:0]           rd_next;
  logic                  misaligned;
  logic                  misalign_evt;
  logic                  scrubbing;
  logic                  run;

  // Upper address bits only alias onto the array, so they are ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_mem_w_addr[31:DEPTH_LOG2+2]};

  assign w_idx = i_mem_w_addr[DEPTH_LOG2+1:2];
  assign r_idx = i_mem_r_addr[DEPTH_LOG2+1:2];

`ifdef DRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, SCRUB, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [DEPTH_LOG2-1:0] scrub_idx_next;

  // Scrub FSM state and index registers.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      scrub_idx <= '0;
    end else begin
      state     <= state_next;
      scrub_idx <= scrub_idx_next;
    end
  end

  // Walk every word index once after reset, then hand over to normal use.
  always_comb begin
    state_next     = state;
    scrub_idx_next = scrub_idx;
    case (state)
      IDLE:  state_next = SCRUB;
      SCRUB: begin
        scrub_idx_next = scrub_idx + 1'b1;
        if (scrub_idx == '1) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign scrubbing = (state == SCRUB);
  assign run       = (state == RUN);
  assign o_busy    = scrubbing;
`else
  assign scrubbing = 1'b0;
  assign run       = 1'b1;
  assign scrub_idx = '0;
  assign o_busy    = 1'b0;
`endif

  // Decode store size into byte-lane enables and replicated lane data.
  always_comb begin
    lane_en    = 4'b0000;
    lane_data  = i_mem_w_data;
    misaligned = 1'b0;
    case (i_mem_len)
      2'b00: begin
        lane_en   = 4'b0001 << i_mem_w_addr[1:0];
        lane_data = {4{i_mem_w_data[7:0]}};
      end
      2'b01: begin
        lane_data = {2{i_mem_w_data[15:0]}};
        if (i_mem_w_addr[0]) misaligned = 1'b1;
        else                 lane_en    = i_mem_w_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (i_mem_w_addr[1:0] != 2'b00) misaligned = 1'b1;
        else                            lane_en    = 4'b1111;
      end
    endcase
  end

  // Scrub owns the write port; external stores only land when running.
  // Writes are also gated by reset so a store under reset never lands.
  assign wr_idx       = scrubbing ? scrub_idx : w_idx;
  assign wr_word      = scrubbing ? 32'h0 : lane_data;
  assign wr_be        = !i_reset_n ? 4'b0000 :
                        scrubbing  ? 4'b1111 :
                        (run && i_mem_we) ? lane_en : 4'b0000;
  assign misalign_evt = run && i_mem_we && misaligned;

  // Byte-enabled array write.
  always_ff @(posedge i_Clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
    end
  end

  // Write-first merge: lanes being written this edge bypass the array.
  assign mem_word = mem[r_idx];
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_next[8*gi +: 8] = (wr_be[gi] && (wr_idx == r_idx)) ?
                                wr_word[8*gi +: 8] : mem_word[8*gi +: 8];
  end

  // Registered read data and the address it belongs to.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mem_r_data <= 32'h0;
      o_mem_r_addr <= 32'h0;
    end else begin
      o_mem_r_data <= run ? rd_next : 32'h0;
      o_mem_r_addr <= i_mem_r_addr;
    end
  end

  // Misaligned-store pulse and saturating drop counter.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_misalign     <= 1'b0;
      o_misalign_cnt <= 8'h00;
    end else begin
      o_misalign <= misalign_evt;
      if (misalign_evt && (o_misalign_cnt != 8'hFF))
        o_misalign_cnt <= o_misalign_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Testbench for data_ram (DEPTH_LOG2 = 4). Random and directed stores and
// reads are checked against a byte-addressed behavioural memory model.
// Also runs with DRAM_CLEAR_EN defined; then the scrub sequence is checked.
module tb_data_ram;

  localparam int DL2 = 4;
  localparam int WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] r_addr = '0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic [1:0]  len = '0;
  logic [31:0] r_data;
  logic [31:0] r_addr_o;
  logic        mis;
  logic [7:0]  mis_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] model_mem [WORDS];
  logic [31:0] exp_rdata;
  logic [31:0] exp_raddr;
  logic        exp_mis;
  int          exp_cnt = 0;

  data_ram #(.DEPTH_LOG2(DL2), .INIT_FILE("")) dut (
    .i_Clk(clk), .i_reset_n(rst_n), .i_mem_we(we),
    .i_mem_r_addr(r_addr), .i_mem_w_addr(w_addr), .i_mem_w_data(w_data),
    .i_mem_len(len), .o_mem_r_data(r_data), .o_mem_r_addr(r_addr_o),
    .o_misalign(mis), .o_misalign_cnt(mis_cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int word_of(input logic [31:0] a);
    return int'((a % 32'd64) / 32'd4);
  endfunction

  function automatic bit is_aligned(input logic [1:0] l, input logic [31:0] a);
    if (l == 2'd0) return 1'b1;
    if (l == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] l, input logic [31:0] a);
    int sh;
    logic [31:0] mask;
    if (l == 2'd0) begin
      sh = 8 * int'(a % 4);
      mask = 32'hFF << sh;
      return (old & ~mask) | ((d & 32'hFF) << sh);
    end
    if (l == 2'd1) begin
      sh = 16 * int'((a % 4) / 2);
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  // One clock: apply inputs, update the model, sample 1 time unit after the edge.
  task automatic drive(input logic s_we, input logic [1:0] s_len, input logic [31:0] s_wa,
                       input logic [31:0] s_wd, input logic [31:0] s_ra);
    int wi;
    we = s_we; len = s_len; w_addr = s_wa; w_data = s_wd; r_addr = s_ra;
    wi = word_of(s_wa);
    exp_mis = 1'b0;
    if (s_we) begin
      if (is_aligned(s_len, s_wa)) model_mem[wi] = merge(model_mem[wi], s_wd, s_len, s_wa);
      else begin
        exp_mis = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
    exp_rdata = model_mem[word_of(s_ra)];
    exp_raddr = s_ra;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", r_data); end
    n_checks++; if (r_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_raddr got=%h want=0", r_addr_o); end
    n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL reset_mis got=%b want=0", mis); end
    n_checks++; if (mis_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_cnt got=%0d want=0", mis_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    exp_cnt = 0;
    $display("reset: outputs cleared");
  endtask

`ifdef DRAM_CLEAR_EN
  task automatic test_scrub();
    int busy_cycles = 0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    n_checks++;
    if (busy_cycles != WORDS) begin n_fail++; $display("FAIL scrub_busy_cycles got=%0d want=%0d", busy_cycles, WORDS); end
    $display("scrub: busy for %0d cycles", busy_cycles);
    for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b0, 2'd2, 32'h0, 32'h0, 32'(i * 4));
      n_checks++;
      if (r_data !== 32'h0) begin n_fail++; $display("FAIL scrub_zero idx=%0d got=%h want=0", i, r_data); end
      $display("scrub read idx=%0d data=%h", i, r_data);
    end
  endtask
`else
  task automatic test_scrub();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_tied got=%b want=0 cycle=%0d", busy, c); end
    end
    $display("scrub: disabled, busy held low");
  endtask
`endif

  task automatic preload();
    for (int i = 0; i < WORDS; i++) drive(1'b1, 2'd2, 32'(i * 4), $urandom, 32'h0);
  endtask

  task automatic test_byte_store();
    drive(1'b1, 2'd2, 32'h100, 32'h11223344, 32'h0);
    drive(1'b1, 2'd0, 32'h102, 32'hFFFFFFAB, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h100);
    n_checks++; if (r_data !== 32'h11AB3344) begin n_fail++; $display("FAIL byte_store got=%h want=11ab3344", r_data); end
    n_checks++; if (r_addr_o !== 32'h100) begin n_fail++; $display("FAIL byte_addr got=%h want=00000100", r_addr_o); end
    $display("byte store: data=%h addr=%h", r_data, r_addr_o);
  endtask

  task automatic test_half_word();
    drive(1'b1, 2'd2, 32'h40, 32'h0, 32'h0);
    drive(1'b1, 2'd1, 32'h42, 32'h0000BEEF, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h40);
    n_checks++; if (r_data !== 32'hBEEF0000) begin n_fail++; $display("FAIL half_store got=%h want=beef0000", r_data); end
    $display("half store: data=%h", r_data);
    drive(1'b1, 2'd2, 32'h40, 32'hDEADBEEF, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h40);
    n_checks++; if (r_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_store got=%h want=deadbeef", r_data); end
    $display("word store: data=%h", r_data);
  endtask

  task automatic test_misalign();
    drive(1'b1, 2'd2, 32'h80, 32'h0BADF00D, 32'h0);
    drive(1'b1, 2'd2, 32'h83, 32'h12345678, 32'h0);
    n_checks++; if (mis !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse got=%b want=1", mis); end
    n_checks++; if (mis_cnt !== 8'd1) begin n_fail++; $display("FAIL misalign_cnt1 got=%0d want=1", mis_cnt); end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h80);
    n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL misalign_one_cycle got=%b want=0", mis); end
    n_checks++; if (r_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL misalign_nowrite got=%h want=0badf00d", r_data); end
    $display("misaligned word: cnt=%0d word=%h", mis_cnt, r_data);
    drive(1'b1, 2'd1, 32'h81, 32'hFFFF, 32'h80);
    n_checks++; if (mis !== 1'b1 || mis_cnt !== 8'd2) begin n_fail++; $display("FAIL misalign_half got=%b/%0d want=1/2", mis, mis_cnt); end
    n_checks++; if (r_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL misalign_half_nowrite got=%h want=0badf00d", r_data); end
    for (int i = 0; i < 300; i++) drive(1'b1, 2'd2, 32'h83, $urandom, 32'h0);
    n_checks++; if (mis_cnt !== 8'd255) begin n_fail++; $display("FAIL misalign_sat got=%0d want=255", mis_cnt); end
    $display("misaligned saturation: cnt=%0d", mis_cnt);
  endtask

  task automatic test_collision();
    drive(1'b1, 2'd2, 32'h20, 32'hAAAAAAAA, 32'h0);
    drive(1'b1, 2'd0, 32'h21, 32'h55, 32'h23);
    n_checks++; if (r_data !== 32'hAAAA55AA) begin n_fail++; $display("FAIL collision_data got=%h want=aaaa55aa", r_data); end
    n_checks++; if (r_addr_o !== 32'h23) begin n_fail++; $display("FAIL collision_addr got=%h want=00000023", r_addr_o); end
    $display("collision: data=%h addr=%h", r_data, r_addr_o);
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'd2, 32'h40, 32'hCAFEF00D, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h00);
    n_checks++; if (r_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap got=%h want=cafef00d", r_data); end
    $display("wrap: data=%h", r_data);
  endtask

  task automatic test_we_low();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      drive(1'b0, 2'($urandom_range(0, 3)), a & 32'hFFFF_FFFC, $urandom, 32'h0);
      drive(1'b0, 2'd0, 32'h0, 32'h0, a & 32'hFFFF_FFFC);
      n_checks++;
      if (r_data !== exp_rdata) begin n_fail++; $display("FAIL we_low addr=%h got=%h want=%h", a, r_data, exp_rdata); end
      $display("we low: addr=%h data=%h", a & 32'hFFFF_FFFC, r_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, ra);
      n_checks++;
      if (r_data !== exp_rdata || r_addr_o !== exp_raddr || mis !== exp_mis || mis_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL random i=%0d got=%h/%h/%b/%0d want=%h/%h/%b/%0d", i, r_data, r_addr_o, mis, mis_cnt,
                 exp_rdata, exp_raddr, exp_mis, exp_cnt);
      end
      $display("random %0d: raddr=%h data=%h mis=%b cnt=%0d", i, r_addr_o, r_data, mis, mis_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h37);
    old = model_mem[word_of(32'h0C)];
    we = 1'b1; len = 2'd2; w_addr = 32'h0C; w_data = ~old; r_addr = 32'h0C;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (r_data !== 32'h0 || r_addr_o !== 32'h0) begin n_fail++; $display("FAIL midreset_read got=%h/%h want=0/0", r_data, r_addr_o); end
    n_checks++; if (mis !== 1'b0 || mis_cnt !== 8'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_flags got=%b/%0d/%b want=0/0/0", mis, mis_cnt, busy); end
    @(posedge clk); #1;
    we = 1'b0;
    rst_n = 1'b1;
    exp_cnt = 0;
    $display("mid-cycle reset: outputs cleared");
`ifdef DRAM_CLEAR_EN
    test_scrub();
`else
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0C);
    n_checks++; if (r_data !== old) begin n_fail++; $display("FAIL midreset_nostore got=%h want=%h", r_data, old); end
    $display("mid-cycle reset: store dropped, word=%h", r_data);
`endif
  endtask

  initial begin
    test_reset();
    test_scrub();
    preload();
    test_byte_store();
    test_half_word();
    test_misalign();
    test_collision();
    test_wrap();
    test_we_low();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
